// File: rtl/j2c_pkg.sv
// Shared types and constants for the j2c serial line scheduler.
// Imported by the arbiter and the scheduler top.
package j2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH
    } state_t;

    localparam logic SDA_IDLE = 1'b1;
    localparam logic SCL_IDLE = 1'b1;

    // Counter width helper: never narrower than one bit.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/j2c_rr_arbiter.sv
// Round-robin winner search starting one past the pointer.
// Purely combinational; the pointer register lives in the caller.
module j2c_rr_arbiter
    import j2c_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW = min1_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/j2c_sched.sv
// Shares one sda/scl line between NUM_REQ requesters: round-robin
// grant, word latch, then start / LSB-first bits / stop framing.
module j2c_sched
    import j2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MESSAGE_LENGTH = 8,
    parameter int CLK_DIV        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                grant,
    output logic                              busy,
    output logic                              done,
    output logic                              sda,
    output logic                              scl
);

    localparam int PW = min1_clog2(NUM_REQ);
    localparam int BW = min1_clog2(MESSAGE_LENGTH);
    localparam int DW = min1_clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(MESSAGE_LENGTH - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);

    state_t                    state;
    logic [PW-1:0]             last;
    logic [PW-1:0]             win_idx;
    logic [NUM_REQ-1:0]        arb_gnt;
    logic                      arb_valid;
    logic [MESSAGE_LENGTH-1:0] word;
    logic [MESSAGE_LENGTH-1:0] win_word;
    logic [BW-1:0]             bit_idx;
    logic [BW-1:0]             bit_nxt;
    logic [DW-1:0]             div;

    j2c_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (last),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign win_word = req_data[int'(win_idx)*MESSAGE_LENGTH +: MESSAGE_LENGTH];
    assign bit_nxt  = bit_idx + BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= PTR_RST;
            bit_idx <= '0;
            div     <= '0;
            word    <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sda     <= SDA_IDLE;
            scl     <= SCL_IDLE;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            if (state == IDLE) begin
                sda     <= SDA_IDLE;
                scl     <= SCL_IDLE;
                busy    <= 1'b0;
                div     <= '0;
                bit_idx <= '0;
                // Outputs for START are loaded together with the grant.
                if (arb_valid) begin
                    grant <= arb_gnt;
                    word  <= win_word;
                    last  <= win_idx;
                    state <= START;
                    sda   <= 1'b0;
                    scl   <= 1'b1;
                end
            end else begin
                busy <= 1'b1;
                if (div != DIV_LAST) begin
                    div <= div + DW'(1);
                end else begin
                    div <= '0;
                    unique case (state)
                        START: begin
                            state   <= BIT_LOW;
                            bit_idx <= '0;
                            scl     <= 1'b0;
                            sda     <= word[0];
                        end
                        BIT_LOW: begin
                            state <= BIT_HIGH;
                            scl   <= 1'b1;
                        end
                        BIT_HIGH: begin
                            scl <= 1'b0;
                            if (bit_idx == BIT_LAST) begin
                                state <= STOP_LOW;
                                sda   <= 1'b0;
                            end else begin
                                state   <= BIT_LOW;
                                bit_idx <= bit_nxt;
                                sda     <= word[bit_nxt];
                            end
                        end
                        STOP_LOW: begin
                            state <= STOP_HIGH;
                            scl   <= 1'b1;
                            sda   <= 1'b0;
                        end
                        STOP_HIGH: begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sda   <= SDA_IDLE;
                            scl   <= SCL_IDLE;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_j2c_sched.sv
// Self-checking bench for j2c_sched: vector table, hand sequences
// and random frames against a frame-level reference model.
module tb_j2c_sched;

    localparam int NR = 4;
    localparam int ML = 8;
    localparam int CD = 2;
    localparam int FL = (2*ML + 3) * CD;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*ML-1:0] req_data = '0;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             done;
    logic             sda;
    logic             scl;

    int n_checks = 0;
    int n_errors = 0;
    int m_last;

    typedef struct packed {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  g;
        logic [7:0]  w;
    } vec_t;

    vec_t tbl [10];

    j2c_sched #(
        .NUM_REQ        (NR),
        .MESSAGE_LENGTH (ML),
        .CLK_DIV        (CD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .busy     (busy),
        .done     (done),
        .sda      (sda),
        .scl      (scl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected {grant, busy, done, sda, scl} k cycles after the grant.
    function automatic logic [7:0] exp_line(input int k, input logic [7:0] w,
                                            input logic [3:0] g);
        int   seg;
        logic s_sda;
        logic s_scl;
        if (k == 0) return {g, 4'b0001};
        if (k >= FL) return {4'b0000, 4'b0111};
        seg = k / CD;
        if (seg == 0) begin
            s_sda = 1'b0;
            s_scl = 1'b1;
        end else if (seg <= 2*ML) begin
            s_sda = w[3'((seg - 1) / 2)];
            s_scl = ((seg - 1) % 2) == 1;
        end else if (seg == 2*ML + 1) begin
            s_sda = 1'b0;
            s_scl = 1'b0;
        end else begin
            s_sda = 1'b0;
            s_scl = 1'b1;
        end
        return {4'b0000, 1'b1, 1'b0, s_sda, s_scl};
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int o = 1; o <= NR; o++) begin
            int i = (last + o) % NR;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [3:0] g);
        for (int i = 0; i < NR; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_frame(input string tag, input logic [3:0] exp_g,
                             input logic [7:0] exp_w, input int abort_at,
                             input bit stir, input logic [31:0] stir_data,
                             input logic [3:0] stir_req);
        bit         got = 1'b0;
        logic       ps = 1'b1;
        logic       pc = 1'b1;
        logic [7:0] rx = '0;
        int         nb = 0;
        int         viol = 0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(posedge clk);
            #1;
            got = (grant != '0);
        end
        if (!got) begin
            check({tag, "_grant"}, {28'b0, grant}, {28'b0, exp_g});
            return;
        end
        for (int k = 0; k <= FL; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("%s_k%0d", tag, k),
                  {24'b0, grant, busy, done, sda, scl},
                  {24'b0, exp_line(k, exp_w, exp_g)});
            if (pc && scl && (sda != ps) && !(k == 0 && !sda) && !(k == FL && sda))
                viol++;
            if (!pc && scl) begin
                if (nb < ML) rx[3'(nb)] = sda;
                nb++;
            end
            ps = sda;
            pc = scl;
            if (stir && k == 0) begin
                req_data = stir_data;
                req      = stir_req;
            end
            if (k == abort_at) return;
        end
        check({tag, "_rx"}, {24'b0, rx}, {24'b0, exp_w});
        check({tag, "_edges"}, nb, ML + 1);
        check({tag, "_line"}, viol, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         nd;
        logic [3:0] r;
        logic [31:0] d;
        int         w;

        tbl[0] = '{4'b1111, 32'h0F0F0F0F, 4'b0001, 8'h0F};
        tbl[1] = '{4'b1111, 32'h0F0F0F0F, 4'b0010, 8'h0F};
        tbl[2] = '{4'b1111, 32'h0F0F0F0F, 4'b0100, 8'h0F};
        tbl[3] = '{4'b1111, 32'h0F0F0F0F, 4'b1000, 8'h0F};
        tbl[4] = '{4'b1111, 32'h0F0F0F0F, 4'b0001, 8'h0F};
        tbl[5] = '{4'b1111, 32'h0F0F0F0F, 4'b0010, 8'h0F};
        tbl[6] = '{4'b1111, 32'h0F0F0F0F, 4'b0100, 8'h0F};
        tbl[7] = '{4'b1100, 32'h0F0F0F0F, 4'b1000, 8'h0F};
        tbl[8] = '{4'b1100, 32'h0F0F0F0F, 4'b0100, 8'h0F};
        tbl[9] = '{4'b0010, 32'h0000A500, 4'b0010, 8'hA5};

        m_last = NR - 1;
        rst = 1'b1;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_c%0d", c),
                  {24'b0, grant, busy, done, sda, scl}, 32'h03);
        end
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle_c%0d", c),
                  {24'b0, grant, busy, done, sda, scl}, 32'h03);
        end

        for (int i = 0; i < 10; i++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            run_frame($sformatf("vec%0d", i), tbl[i].g, tbl[i].w, -1,
                      1'b0, '0, '0);
            m_last = oh2i(tbl[i].g);
        end

        // Word is latched at grant; later data changes must not leak in.
        req      = 4'b0100;
        req_data = 32'h005A0000;
        run_frame("latch", 4'b0100, 8'h5A, -1, 1'b1, 32'h0, 4'b0000);
        m_last = 2;

        // Reset during the 4th data bit.
        req      = 4'b0010;
        req_data = 32'h00003C00;
        run_frame("pre_rst", 4'b0010, 8'h3C, 15, 1'b0, '0, '0);
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        check("rst_mid", {24'b0, grant, busy, done, sda, scl}, 32'h03);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done || busy || !sda || !scl || grant != '0) nd++;
        end
        check("rst_quiet", nd, 0);
        m_last   = NR - 1;
        req      = 4'b1001;
        req_data = 32'hC30000E7;
        run_frame("post_rst", 4'b0001, 8'hE7, -1, 1'b0, '0, '0);
        m_last = 0;

        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom);
            if (r == '0) begin
                req = '0;
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("rnd%0d_idle", it),
                          {24'b0, grant, busy, done, sda, scl}, 32'h03);
                end
            end else begin
                d        = $urandom;
                w        = rr_pick(r, m_last);
                req      = r;
                req_data = d;
                run_frame($sformatf("rnd%0d", it), 4'(1 << w), d[w*8 +: 8],
                          -1, 1'b1, $urandom, 4'($urandom));
                m_last = w;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
